// File: rtl/call_return_unit_pkg.sv
// Shared definitions for the call/return unit: FSM states and default sizing.
package call_return_unit_pkg;

  localparam int         CRU_AW      = 10;
  localparam int         CRU_DEPTH   = 8;
  localparam logic [9:0] CRU_IRQ_VEC = 10'h3F0;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_RET_WAIT  = 2'd1,
    ST_RETI_WAIT = 2'd2
  } state_t;

  function automatic int depthWidth(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/call_return_unit_depth_tracker.sv
// Saturating up/down counter mirroring the occupancy of the external return-address LIFO.
module call_return_unit_depth_tracker #(
  parameter int DEPTH = 8,
  parameter int DW    = 4
) (
  input  logic          i_clk,
  input  logic          i_rst_n,
  input  logic          i_inc,
  input  logic          i_dec,
  output logic [DW-1:0] o_depth,
  output logic          o_full,
  output logic          o_empty
);

  logic [DW-1:0] r_depth;

  assign o_full  = (r_depth == DW'(DEPTH));
  assign o_empty = (r_depth == '0);
  assign o_depth = r_depth;

  // Out-of-range requests are ignored so the count can never wrap.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_depth <= '0;
    end else if (i_inc && !i_dec && !o_full) begin
      r_depth <= r_depth + DW'(1);
    end else if (i_dec && !i_inc && !o_empty) begin
      r_depth <= r_depth - DW'(1);
    end
  end

endmodule

// File: rtl/call_return_unit.sv
// Call/return/interrupt sequencer driving the return-address stack and the PC load mux.
module call_return_unit
  import call_return_unit_pkg::*;
#(
  parameter int            AW      = CRU_AW,
  parameter int            DEPTH   = CRU_DEPTH,
  parameter logic [AW-1:0] IRQ_VEC = AW'(CRU_IRQ_VEC)
) (
  input  logic                         i_clk,
  input  logic                         i_rst_n,
  input  logic                         i_call_req,
  input  logic                         i_ret_req,
  input  logic                         i_reti_req,
  input  logic                         i_ei,
  input  logic                         i_di,
  input  logic                         i_irq,
  input  logic [AW-1:0]                i_pc,
  input  logic [AW-1:0]                i_target,
  input  logic                         i_zflag_in,
  input  logic [AW-1:0]                i_outpop,
  output logic                         o_push,
  output logic                         o_pop,
  output logic [AW-1:0]                o_inpush,
  output logic                         o_pc_load,
  output logic [AW-1:0]                o_pc_next,
  output logic                         o_stall,
  output logic                         o_z_load,
  output logic                         o_z_restore,
  output logic [$clog2(DEPTH+1)-1:0]   o_depth,
  output logic                         o_ie,
  output logic                         o_fault
);

  localparam int DW = depthWidth(DEPTH);

  state_t  r_state;
  state_t  w_nextState;
  logic    r_ie;
  logic    r_fault;
  logic    r_shadowZ;
  logic    w_inc;
  logic    w_dec;
  logic    w_full;
  logic    w_empty;
  logic    w_faultSet;
  logic    w_irqTake;
  logic    w_retiDone;
  logic [DW-1:0] w_depth;

  call_return_unit_depth_tracker #(
    .DEPTH (DEPTH),
    .DW    (DW)
  ) u_depth (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_inc   (w_inc),
    .i_dec   (w_dec),
    .o_depth (w_depth),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_push      = 1'b0;
    o_pop       = 1'b0;
    o_inpush    = '0;
    o_pc_load   = 1'b0;
    o_pc_next   = '0;
    o_stall     = 1'b0;
    o_z_load    = 1'b0;
    w_inc       = 1'b0;
    w_dec       = 1'b0;
    w_faultSet  = 1'b0;
    w_irqTake   = 1'b0;
    w_retiDone  = 1'b0;

    unique case (r_state)
      ST_IDLE: begin
        if (i_call_req) begin
          if (!w_full) begin
            o_push    = 1'b1;
            o_inpush  = i_pc + AW'(1);
            o_pc_load = 1'b1;
            o_pc_next = i_target;
            w_inc     = 1'b1;
          end else begin
            w_faultSet = 1'b1;
          end
        end else if (i_ret_req || i_reti_req) begin
          if (!w_empty) begin
            o_pop       = 1'b1;
            o_stall     = 1'b1;
            w_dec       = 1'b1;
            w_nextState = i_ret_req ? ST_RET_WAIT : ST_RETI_WAIT;
          end else begin
            w_faultSet = 1'b1;
          end
        end else if (i_irq && r_ie) begin
          // The interrupted instruction has not executed, so its own PC is saved.
          if (!w_full) begin
            o_push    = 1'b1;
            o_inpush  = i_pc;
            o_pc_load = 1'b1;
            o_pc_next = IRQ_VEC;
            w_inc     = 1'b1;
            w_irqTake = 1'b1;
          end else begin
            w_faultSet = 1'b1;
          end
        end
      end
      ST_RET_WAIT: begin
        o_pc_load   = 1'b1;
        o_pc_next   = i_outpop;
        w_nextState = ST_IDLE;
      end
      ST_RETI_WAIT: begin
        o_pc_load   = 1'b1;
        o_pc_next   = i_outpop;
        o_z_load    = 1'b1;
        w_retiDone  = 1'b1;
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase

    // Register state already reads as idle under reset, but inputs could still fire strobes.
    if (!i_rst_n) begin
      o_push     = 1'b0;
      o_pop      = 1'b0;
      o_pc_load  = 1'b0;
      o_stall    = 1'b0;
      o_z_load   = 1'b0;
      w_inc      = 1'b0;
      w_dec      = 1'b0;
      w_faultSet = 1'b0;
      w_irqTake  = 1'b0;
      w_retiDone = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ie <= 1'b0;
    end else if (w_irqTake || i_di) begin
      r_ie <= 1'b0;
    end else if (i_ei || w_retiDone) begin
      r_ie <= 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_shadowZ <= 1'b0;
      r_fault   <= 1'b0;
    end else begin
      if (w_irqTake) begin
        r_shadowZ <= i_zflag_in;
      end
      if (w_faultSet) begin
        r_fault <= 1'b1;
      end
    end
  end

  assign o_z_restore = r_shadowZ;
  assign o_depth     = w_depth;
  assign o_ie        = r_ie;
  assign o_fault     = r_fault;

endmodule

// File: tb/tb_call_return_unit.sv
// Directed table plus randomized run of call_return_unit against a stack-based reference model.
module tb_call_return_unit;
  import call_return_unit_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       callReq, retReq, retiReq, ei, di, irq, zf;
  logic [9:0] pc, target, outpop;
  logic       push, pop, pcLoad, stall, zLoad, zRestore, ie, fault;
  logic [9:0] inpush, pcNext;
  logic [3:0] depth;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  call_return_unit dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_call_req  (callReq),
    .i_ret_req   (retReq),
    .i_reti_req  (retiReq),
    .i_ei        (ei),
    .i_di        (di),
    .i_irq       (irq),
    .i_pc        (pc),
    .i_target    (target),
    .i_zflag_in  (zf),
    .i_outpop    (outpop),
    .o_push      (push),
    .o_pop       (pop),
    .o_inpush    (inpush),
    .o_pc_load   (pcLoad),
    .o_pc_next   (pcNext),
    .o_stall     (stall),
    .o_z_load    (zLoad),
    .o_z_restore (zRestore),
    .o_depth     (depth),
    .o_ie        (ie),
    .o_fault     (fault)
  );

  // req = {call, ret, reti, ei, di, irq}; strb = {push, pop, pc_load, stall, z_load}
  typedef struct {
    logic [5:0] req;
    logic [9:0] pc, target, outpop;
    logic       zf;
    logic [4:0] strb;
    logic [9:0] inpush, pcNext;
    logic       zr;
    logic [3:0] depth;
    logic       ie, fault;
  } vec_t;

  vec_t vecs[$];

  task automatic addVec(input logic [5:0] req, input logic [9:0] p, t, op, input logic z,
                        input logic [4:0] s, input logic [9:0] ip, pn, input logic zr,
                        input logic [3:0] d, input logic e, f);
    vec_t v;
    v.req = req; v.pc = p; v.target = t; v.outpop = op; v.zf = z;
    v.strb = s; v.inpush = ip; v.pcNext = pn; v.zr = zr;
    v.depth = d; v.ie = e; v.fault = f;
    vecs.push_back(v);
  endtask

  task automatic checkOutput(input string name, input logic [9:0] act, input logic [9:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [5:0] req, input logic [9:0] p, t, op, input logic z);
    {callReq, retReq, retiReq, ei, di, irq} = req;
    pc = p; target = t; outpop = op; zf = z;
  endtask

  task automatic runCycle(input string tag, input logic [4:0] s, input logic [9:0] ip, pn,
                          input logic zr, input logic [3:0] d, input logic e, f);
    #1;
    checkOutput({tag, " push"}, {9'd0, push}, {9'd0, s[4]});
    checkOutput({tag, " pop"}, {9'd0, pop}, {9'd0, s[3]});
    checkOutput({tag, " pc_load"}, {9'd0, pcLoad}, {9'd0, s[2]});
    checkOutput({tag, " stall"}, {9'd0, stall}, {9'd0, s[1]});
    checkOutput({tag, " z_load"}, {9'd0, zLoad}, {9'd0, s[0]});
    if (s[4]) checkOutput({tag, " inpush"}, inpush, ip);
    if (s[2]) checkOutput({tag, " pc_next"}, pcNext, pn);
    if (s[0]) checkOutput({tag, " z_restore"}, {9'd0, zRestore}, {9'd0, zr});
    @(posedge clk);
    #1;
    checkOutput({tag, " depth"}, {6'd0, depth}, {6'd0, d});
    checkOutput({tag, " ie"}, {9'd0, ie}, {9'd0, e});
    checkOutput({tag, " fault"}, {9'd0, fault}, {9'd0, f});
  endtask

  // Reference model state: the stack itself plus the pending return kind.
  logic [9:0] mStack[$];
  int         mPending;
  logic [9:0] mLastPop;
  logic       mIe, mFault, mShadow;

  initial begin
    rst_n = 1'b0;
    applyStimulus(6'b100001, 10'h123, 10'h200, 10'h000, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset push", {9'd0, push}, 10'd0);
    checkOutput("reset pc_load", {9'd0, pcLoad}, 10'd0);
    checkOutput("reset depth", {6'd0, depth}, 10'd0);
    checkOutput("reset ie", {9'd0, ie}, 10'd0);
    checkOutput("reset fault", {9'd0, fault}, 10'd0);
    @(negedge clk);
    applyStimulus(6'b0, 10'h0, 10'h0, 10'h0, 1'b0);
    rst_n = 1'b1;

    addVec(6'b100000, 10'h010, 10'h100, 10'h000, 0, 5'b10100, 10'h011, 10'h100, 0, 1, 0, 0);
    addVec(6'b010000, 10'h100, 10'h000, 10'h000, 0, 5'b01010, 10'h000, 10'h000, 0, 0, 0, 0);
    addVec(6'b000000, 10'h100, 10'h000, 10'h011, 0, 5'b00100, 10'h000, 10'h011, 0, 0, 0, 0);
    addVec(6'b000100, 10'h011, 10'h000, 10'h000, 0, 5'b00000, 10'h000, 10'h000, 0, 0, 1, 0);
    addVec(6'b000001, 10'h020, 10'h000, 10'h000, 1, 5'b10100, 10'h020, 10'h3F0, 0, 1, 0, 0);
    addVec(6'b001000, 10'h3F0, 10'h000, 10'h000, 0, 5'b01010, 10'h000, 10'h000, 0, 0, 0, 0);
    addVec(6'b000000, 10'h3F1, 10'h000, 10'h020, 0, 5'b00101, 10'h000, 10'h020, 1, 0, 1, 0);
    addVec(6'b100001, 10'h030, 10'h200, 10'h000, 0, 5'b10100, 10'h031, 10'h200, 0, 1, 1, 0);
    addVec(6'b000001, 10'h200, 10'h000, 10'h000, 0, 5'b10100, 10'h200, 10'h3F0, 0, 2, 0, 0);
    for (int i = 0; i < 6; i++)
      addVec(6'b100000, 10'h040 + 10'(i), 10'h300 + 10'(i), 10'h000, 0, 5'b10100,
             10'h041 + 10'(i), 10'h300 + 10'(i), 0, 4'(3 + i), 0, 0);
    addVec(6'b100000, 10'h050, 10'h3AA, 10'h000, 0, 5'b00000, 10'h000, 10'h000, 0, 8, 0, 1);

    foreach (vecs[k]) begin
      @(negedge clk);
      applyStimulus(vecs[k].req, vecs[k].pc, vecs[k].target, vecs[k].outpop, vecs[k].zf);
      runCycle($sformatf("vec%0d", k), vecs[k].strb, vecs[k].inpush, vecs[k].pcNext,
               vecs[k].zr, vecs[k].depth, vecs[k].ie, vecs[k].fault);
    end

    // Reset asserted while waiting for the popped return address.
    @(negedge clk);
    applyStimulus(6'b010000, 10'h3AB, 10'h000, 10'h000, 0);
    runCycle("ret before reset", 5'b01010, 10'h0, 10'h0, 0, 7, 0, 1);
    @(negedge clk);
    applyStimulus(6'b0, 10'h3AB, 10'h000, 10'h055, 0);
    rst_n = 1'b0;
    #1;
    checkOutput("abort pc_load", {9'd0, pcLoad}, 10'd0);
    checkOutput("abort pop", {9'd0, pop}, 10'd0);
    checkOutput("abort depth", {6'd0, depth}, 10'd0);
    checkOutput("abort fault", {9'd0, fault}, 10'd0);
    @(negedge clk);
    rst_n = 1'b1;
    runCycle("idle after abort", 5'b00000, 10'h0, 10'h0, 0, 0, 0, 0);

    @(negedge clk);
    applyStimulus(6'b010000, 10'h000, 10'h000, 10'h000, 0);
    runCycle("ret empty", 5'b00000, 10'h0, 10'h0, 0, 0, 0, 1);
    @(negedge clk);
    applyStimulus(6'b001000, 10'h000, 10'h000, 10'h000, 0);
    runCycle("reti empty", 5'b00000, 10'h0, 10'h0, 0, 0, 0, 1);

    @(negedge clk);
    applyStimulus(6'b0, 10'h0, 10'h0, 10'h0, 0);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    mStack = {};
    mPending = 0; mLastPop = '0; mIe = 0; mFault = 0; mShadow = 0;

    for (int c = 0; c < 400; c++) begin
      logic [5:0] req;
      logic [9:0] p, t, op, ip, pn;
      logic       z, zr, irqTake, retiDone;
      logic [4:0] s;
      @(negedge clk);
      req = {($urandom_range(0, 4) == 0), ($urandom_range(0, 4) == 0),
             ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) == 0)};
      p = 10'($urandom); t = 10'($urandom); z = 1'($urandom);
      op = (mPending != 0) ? mLastPop : 10'($urandom);
      s = '0; ip = '0; pn = '0; zr = 0; irqTake = 0; retiDone = 0;
      if (mPending != 0) begin
        s[2] = 1; pn = mLastPop;
        if (mPending == 2) begin s[0] = 1; zr = mShadow; retiDone = 1; end
        mPending = 0;
      end else if (req[5]) begin
        if (mStack.size() < 8) begin
          s[4] = 1; s[2] = 1; ip = p + 10'd1; pn = t; mStack.push_back(ip);
        end else mFault = 1;
      end else if (req[4] || req[3]) begin
        if (mStack.size() > 0) begin
          s[3] = 1; s[1] = 1; mLastPop = mStack.pop_back(); mPending = req[4] ? 1 : 2;
        end else mFault = 1;
      end else if (req[0] && mIe) begin
        if (mStack.size() < 8) begin
          s[4] = 1; s[2] = 1; ip = p; pn = 10'h3F0; mStack.push_back(p);
          mShadow = z; irqTake = 1;
        end else mFault = 1;
      end
      if (irqTake || req[1]) mIe = 0;
      else if (req[2] || retiDone) mIe = 1;
      applyStimulus(req, p, t, op, z);
      runCycle($sformatf("rand%0d", c), s, ip, pn, zr, 4'(mStack.size()), mIe, mFault);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
